// File: rtl/nox_and.sv
// Masked XNOR-AND literal evaluator: one registered stage producing per-slot matches and clause summary flags.
// Optional match_count popcount output is enabled by defining NOX_AND_COUNT_EN.
module nox_and #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] assignment,
  input  logic [WIDTH-1:0] clause_type,
  input  logic [WIDTH-1:0] clause_mask,
  output logic             out_valid,
  output logic [WIDTH-1:0] na_out,
  output logic             any_match,
`ifdef NOX_AND_COUNT_EN
  output logic             all_match,
  output logic [CNT_W-1:0] match_count
`else
  output logic             all_match
`endif
);

  // A clause with no literals present can never be fully satisfied.
  function automatic logic all_fn(input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] mask);
    return (na == mask) && (|mask);
  endfunction

`ifdef NOX_AND_COUNT_EN
  function automatic logic [CNT_W-1:0] popcount_fn(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction
`endif

  logic [WIDTH-1:0] na_p0_d;
  logic             any_p0_d;
  logic             all_p0_d;

  logic             vld_p1_q;
  logic [WIDTH-1:0] na_p1_q;
  logic             any_p1_q;
  logic             all_p1_q;

  // Stage p0: combinational per-slot evaluation and summary flags
  always_comb begin
    na_p0_d  = clause_mask & ~(assignment ^ clause_type);
    any_p0_d = |na_p0_d;
    all_p0_d = all_fn(na_p0_d, clause_mask);
  end

  // Stage p1: results load only on valid; out_valid tracks in_valid every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      na_p1_q  <= '0;
      any_p1_q <= 1'b0;
      all_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        na_p1_q  <= na_p0_d;
        any_p1_q <= any_p0_d;
        all_p1_q <= all_p0_d;
      end
    end
  end

`ifdef NOX_AND_COUNT_EN
  logic [CNT_W-1:0] cnt_p0_d;
  logic [CNT_W-1:0] cnt_p1_q;

  always_comb begin
    cnt_p0_d = popcount_fn(na_p0_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1_q <= '0;
    end else if (in_valid) begin
      cnt_p1_q <= cnt_p0_d;
    end
  end

  assign match_count = cnt_p1_q;
`endif

  assign out_valid = vld_p1_q;
  assign na_out    = na_p1_q;
  assign any_match = any_p1_q;
  assign all_match = all_p1_q;

endmodule

// File: tb/tb_nox_and.sv
// Bench for nox_and: directed vector table, WIDTH=1 truth table, multi-cycle sequences and randomized model check.
module tb_nox_and;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v8;
  logic [7:0] a8, t8, m8;
  logic       ov8, any8, all8;
  logic [7:0] na8;
  logic       v1, a1, t1, m1;
  logic       ov1, any1, all1;
  logic [0:0] na1;
`ifdef NOX_AND_COUNT_EN
  logic [3:0] mc8;
  logic [0:0] mc1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] e_na;
  logic       e_vld, e_any, e_all;
  int         e_cnt;

  always #5 clk = ~clk;

  nox_and #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .assignment(a8), .clause_type(t8), .clause_mask(m8),
    .out_valid(ov8), .na_out(na8), .any_match(any8),
`ifdef NOX_AND_COUNT_EN
    .all_match(all8), .match_count(mc8)
`else
    .all_match(all8)
`endif
  );

  nox_and #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .assignment(a1), .clause_type(t1), .clause_mask(m1),
    .out_valid(ov1), .na_out(na1), .any_match(any1),
`ifdef NOX_AND_COUNT_EN
    .all_match(all1), .match_count(mc1)
`else
    .all_match(all1)
`endif
  );

  typedef struct {
    logic [7:0] a, t, m;
    logic [7:0] na;
    logic       any, all;
    int         cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a literal counts when present and the variable value equals its polarity.
  function automatic void model(input logic [7:0] a, input logic [7:0] t, input logic [7:0] m,
                                output logic [7:0] na, output logic any, output logic all,
                                output int cnt);
    int present;
    present = 0;
    cnt = 0;
    na = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        present++;
        if (a[i] == t[i]) begin
          na[i] = 1'b1;
          cnt++;
        end
      end
    end
    any = (cnt > 0);
    all = (present > 0) && (cnt == present);
  endfunction

  task automatic check8(input string nm);
    chk({nm, "_vld"}, 32'(ov8), 32'(e_vld));
    chk({nm, "_na"}, 32'(na8), 32'(e_na));
    chk({nm, "_any"}, 32'(any8), 32'(e_any));
    chk({nm, "_all"}, 32'(all8), 32'(e_all));
`ifdef NOX_AND_COUNT_EN
    chk({nm, "_cnt"}, 32'(mc8), 32'(e_cnt));
`endif
  endtask

  task automatic clear_model();
    e_vld = 1'b0; e_na = 8'h00; e_any = 1'b0; e_all = 1'b0; e_cnt = 0;
  endtask

  // Drive one cycle on the 8-bit instance and advance the reference state.
  task automatic apply8(input logic v, input logic [7:0] a, input logic [7:0] t, input logic [7:0] m);
    logic [7:0] na;
    logic       any, all;
    int         cnt;
    v8 = v; a8 = a; t8 = t; m8 = m;
    model(a, t, m, na, any, all, cnt);
    @(posedge clk);
    #1;
    e_vld = v;
    if (v) begin
      e_na = na; e_any = any; e_all = all; e_cnt = cnt;
    end
  endtask

  vec_t       tbl[6];
  logic [7:0] tt_exp;
  logic [2:0] idx;
  logic [7:0] ra;

  initial begin
    rst_n = 1'b0;
    v8 = 1'b1; a8 = 8'h5A; t8 = 8'h5A; m8 = 8'hFF;
    v1 = 1'b0; a1 = 1'b0; t1 = 1'b0; m1 = 1'b0;
    clear_model();

    tbl[0] = '{a: 8'hA5, t: 8'hA5, m: 8'hFF, na: 8'hFF, any: 1'b1, all: 1'b1, cnt: 8};
    tbl[1] = '{a: 8'h0F, t: 8'h00, m: 8'hF0, na: 8'hF0, any: 1'b1, all: 1'b1, cnt: 4};
    tbl[2] = '{a: 8'h0F, t: 8'h00, m: 8'h00, na: 8'h00, any: 1'b0, all: 1'b0, cnt: 0};
    tbl[3] = '{a: 8'h00, t: 8'hFF, m: 8'hFF, na: 8'h00, any: 1'b0, all: 1'b0, cnt: 0};
    tbl[4] = '{a: 8'h3C, t: 8'h3C, m: 8'h0F, na: 8'h0F, any: 1'b1, all: 1'b1, cnt: 4};
    tbl[5] = '{a: 8'h01, t: 8'h00, m: 8'h03, na: 8'h02, any: 1'b1, all: 1'b0, cnt: 1};

    // Reset held across edges with live inputs, then released with in_valid low
    repeat (2) @(posedge clk);
    #1;
    check8("reset_hold");
    chk("reset_hold_na1", 32'(na1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply8(1'b0, 8'hFF, 8'hFF, 8'hFF);
    apply8(1'b0, 8'h12, 8'h12, 8'hFF);
    check8("post_reset_idle");

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      apply8(1'b1, tbl[i].a, tbl[i].t, tbl[i].m);
      chk($sformatf("tbl%0d_vld", i), 32'(ov8), 32'd1);
      chk($sformatf("tbl%0d_na", i), 32'(na8), 32'(tbl[i].na));
      chk($sformatf("tbl%0d_any", i), 32'(any8), 32'(tbl[i].any));
      chk($sformatf("tbl%0d_all", i), 32'(all8), 32'(tbl[i].all));
`ifdef NOX_AND_COUNT_EN
      chk($sformatf("tbl%0d_cnt", i), 32'(mc8), 32'(tbl[i].cnt));
`endif
    end

    // WIDTH=1 truth table, index = {a,t,m}
    tt_exp = 8'h82;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      v1 = 1'b1; a1 = idx[2]; t1 = idx[1]; m1 = idx[0];
      @(posedge clk);
      #1;
      chk($sformatf("tt%0d_na", i), 32'(na1), 32'(tt_exp[idx]));
      chk($sformatf("tt%0d_all", i), 32'(all1), 32'(tt_exp[idx]));
      chk($sformatf("tt%0d_vld", i), 32'(ov1), 32'd1);
    end
    v1 = 1'b0;

    // Hold: valid vector, then idle cycles with changed inputs
    apply8(1'b1, 8'hA5, 8'hA5, 8'hFF);
    check8("hold_load");
    apply8(1'b0, 8'h00, 8'hFF, 8'h0F);
    chk("hold_vld", 32'(ov8), 32'd0);
    chk("hold_na", 32'(na8), 32'hFF);
    check8("hold1");
    apply8(1'b0, 8'h33, 8'hCC, 8'hFF);
    check8("hold2");

    // Back-to-back alternating vectors, no bubbles
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom);
      apply8(1'b1, ra, ra ^ ((k % 2 == 0) ? 8'hFF : 8'h00), 8'hFF);
      chk($sformatf("b2b%0d_vld", k), 32'(ov8), 32'd1);
      chk($sformatf("b2b%0d_na", k), 32'(na8), (k % 2 == 0) ? 32'h00 : 32'hFF);
    end

    // Mid-cycle asynchronous reset clears outputs without a clock edge
    apply8(1'b1, 8'hF0, 8'hF0, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check8("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply8(1'b1, 8'h0F, 8'h00, 8'hF0);
    chk("first_after_rst", 32'(na8), 32'hF0);

    // Randomized stream against the reference model, with an occasional reset
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check8("rand_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      apply8(($urandom_range(3) != 0), 8'($urandom), 8'($urandom),
             ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom));
      check8($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
